// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes and FSM states.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MTHI  = 3'd4,
      MTLO  = 3'd5
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } md_state_t;

   function automatic logic is_muldiv(input md_op_t op);
      return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
   endfunction

endpackage

// File: rtl/b_muldiv.sv
// Iterative radix-2 multiply / restoring divide with architectural HI/LO registers,
// busy interlock and flush cancellation for the EX stage.
module b_muldiv
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_sys_clock,
   input  logic             i_sys_reset_n,
   input  logic             i_b_muldiv_start,
   input  logic [2:0]       i_b_muldiv_op,
   input  logic [WIDTH-1:0] i_b_muldiv_a,
   input  logic [WIDTH-1:0] i_b_muldiv_b,
   input  logic             i_b_muldiv_cancel,
   output logic             o_b_muldiv_busy,
   output logic             o_b_muldiv_done,
   output logic [WIDTH-1:0] o_b_muldiv_hi,
   output logic [WIDTH-1:0] o_b_muldiv_lo
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned W2 = 2 * WIDTH;

   md_state_t        r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a, r_b;
   logic [W2-1:0]    r_acc;
   logic             r_div, r_neg_q, r_neg_r;
   logic [WIDTH-1:0] r_hi, r_lo;
   logic             r_busy, r_done;

   md_op_t           w_op;
   logic             w_signed, w_idle_req, w_accept, w_mthi, w_mtlo;
   logic             w_last, w_iter, w_fix_write;
   logic             w_neg_a, w_neg_b;
   logic [WIDTH-1:0] w_abs_a, w_abs_b;

   // Request decode: only IDLE without a flush accepts anything
   assign w_op       = md_op_t'(i_b_muldiv_op);
   assign w_signed   = (w_op == MULT) || (w_op == DIV);
   assign w_idle_req = (r_state == IDLE) && i_b_muldiv_start && !i_b_muldiv_cancel;
   assign w_accept   = w_idle_req && is_muldiv(w_op);
   assign w_mthi     = w_idle_req && (w_op == MTHI);
   assign w_mtlo     = w_idle_req && (w_op == MTLO);
   assign w_last     = (r_cnt == CW'(WIDTH - 1));
   assign w_iter     = (r_state == CALC) && !i_b_muldiv_cancel;
   assign w_fix_write = (r_state == FIX) && !i_b_muldiv_cancel;

   assign w_neg_a = w_signed && i_b_muldiv_a[WIDTH-1];
   assign w_neg_b = w_signed && i_b_muldiv_b[WIDTH-1];
   assign w_abs_a = w_neg_a ? (~i_b_muldiv_a + WIDTH'(1)) : i_b_muldiv_a;
   assign w_abs_b = w_neg_b ? (~i_b_muldiv_b + WIDTH'(1)) : i_b_muldiv_b;

   // Multiply step: add multiplicand into the upper half, shift the whole accumulator right
   logic [WIDTH:0]   w_sum;
   logic [W2-1:0]    w_mul_nxt;
   assign w_sum     = {1'b0, r_acc[W2-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
   assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

   // Restoring divide step: remainder in the upper half, quotient bits enter the lower half
   logic [WIDTH:0]   w_rem_sh, w_rem_sub;
   logic             w_ge;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [W2-1:0]    w_div_nxt;
   assign w_rem_sh  = {r_acc[W2-1:WIDTH], r_a[WIDTH-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, r_b});
   assign w_rem_sub = w_rem_sh - {1'b0, r_b};
   assign w_rem_nxt = WIDTH'(w_ge ? w_rem_sub : w_rem_sh);
   assign w_div_nxt = {w_rem_nxt, r_acc[WIDTH-2:0], w_ge};

   // Sign fix-up of the magnitude results
   logic [W2-1:0]    w_prod;
   logic [WIDTH-1:0] w_quo, w_rem;
   assign w_prod = r_neg_q ? (~r_acc + W2'(1)) : r_acc;
   assign w_quo  = r_neg_q ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_r ? (~r_acc[W2-1:WIDTH] + WIDTH'(1)) : r_acc[W2-1:WIDTH];

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = CALC;
         CALC:    if (i_b_muldiv_cancel) w_state_nxt = IDLE;
                  else if (w_last)       w_state_nxt = FIX;
         FIX:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_sys_clock or negedge i_sys_reset_n) begin
      if (!i_sys_reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_div   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != IDLE);
         r_done  <= w_fix_write;
         if (w_accept) begin
            r_a     <= w_abs_a;
            r_b     <= w_abs_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_div   <= (w_op == DIV) || (w_op == DIVU);
            // Divide by zero keeps the all-ones quotient unsigned
            r_neg_q <= (w_neg_a ^ w_neg_b) &&
                       !(((w_op == DIV) || (w_op == DIVU)) && (i_b_muldiv_b == '0));
            r_neg_r <= w_neg_a;
         end
         if (w_iter) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_div) begin
               r_acc <= w_div_nxt;
               r_a   <= {r_a[WIDTH-2:0], 1'b0};
            end else begin
               r_acc <= w_mul_nxt;
               r_b   <= {1'b0, r_b[WIDTH-1:1]};
            end
         end
         if (w_fix_write) begin
            if (r_div) begin
               r_hi <= w_rem;
               r_lo <= w_quo;
            end else begin
               r_hi <= w_prod[W2-1:WIDTH];
               r_lo <= w_prod[WIDTH-1:0];
            end
         end
         if (w_mthi) r_hi <= i_b_muldiv_a;
         if (w_mtlo) r_lo <= i_b_muldiv_a;
      end
   end

   assign o_b_muldiv_busy = r_busy;
   assign o_b_muldiv_done = r_done;
   assign o_b_muldiv_hi   = r_hi;
   assign o_b_muldiv_lo   = r_lo;

endmodule

// File: doc/b_muldiv.md
# b_muldiv

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It supersedes the fixed-width, multiply-only HI/LO path and adds signed/unsigned multiply and divide, MTHI/MTLO writes, a busy interlock for stalling the pipeline, and cancellation on pipeline flush. It sits in the EX stage: operands arrive from the ID/EX register, and HI/LO feed the MFHI/MFLO select in ID.

## Interface
- WIDTH, 32, operand/HI/LO width; even, ≥ 4
- i_sys_clock  in  1  clock, rising edge
- i_sys_reset_n  in  1  asynchronous active-low reset
- i_b_muldiv_start  in  1  request valid for one cycle
- i_b_muldiv_op  in  3  operation code (md_op_t): MULT, MULTU, DIV, DIVU, MTHI, MTLO
- i_b_muldiv_a  in  WIDTH  rs operand (multiplicand / dividend / MT source)
- i_b_muldiv_b  in  WIDTH  rt operand (multiplier / divisor)
- i_b_muldiv_cancel  in  1  flush; kills any in-flight or same-cycle operation
- o_b_muldiv_busy  out  1  operation in flight; the pipeline stalls MFHI/MFLO and a new mult/div while high
- o_b_muldiv_done  out  1  one-cycle pulse; HI/LO updated by mult/div
- o_b_muldiv_hi  out  WIDTH  HI register
- o_b_muldiv_lo  out  WIDTH  LO register

## Operation
- Reset, asserted asynchronously: state IDLE, HI=0, LO=0, busy=0, done=0, counter=0.
- States:
  - IDLE → CALC on start & !cancel & op ∈ {MULT, MULTU, DIV, DIVU}.
  - CALC → FIX after WIDTH iterations.
  - FIX → IDLE.
  - CALC/FIX → IDLE on cancel.
- Accept edge:
  - Latch |a| and |b| (signed ops) or raw operands (unsigned ops).
  - Latch result sign: product/quotient = a[MSB]^b[MSB]; remainder = a[MSB].
  - Clear the 2·WIDTH accumulator; counter=0.
- CALC multiply: radix-2 shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator.
- CALC divide: restoring, one quotient bit per cycle, WIDTH+1-bit partial remainder.
- FIX:
  - Apply two's-complement negation per latched signs.
  - Write HI/LO: multiply gives HI=upper and LO=lower product bits; divide gives LO=quotient and HI=remainder.
  - Assert done for the following cycle.
- Divide by zero (b==0, signed or unsigned): completes with normal latency, LO = all-ones, HI = a unmodified.
- Signed overflow, most-negative / −1: LO = most-negative, HI = 0. Magnitude arithmetic yields this naturally; no special case.
- MTHI/MTLO:
  - Accepted only in IDLE with !cancel.
  - Write a into HI or LO at the accept edge.
  - Never assert busy or done.
- start while busy: ignored, no effect on state or HI/LO.
- Cancel:
  - In CALC or FIX: return to IDLE at the next edge, HI/LO unchanged, no done.
  - In IDLE: suppresses a same-cycle start, including MT ops.
- HI/LO change only at a FIX edge or an MT accept edge.

## Timing
- Start sampled at edge k:
  - busy=1 after edge k.
  - Iterations at edges k+1 … k+WIDTH.
  - FIX at edge k+WIDTH+1: HI/LO valid, busy=0, done=1 for one cycle.
- Latency: WIDTH+1 cycles from start to result (33 for WIDTH=32).
- Back-to-back operations: a new start is accepted in the cycle done is high, so throughput is one op per WIDTH+1 cycles.
- busy, done, HI and LO are all registered; no combinational path from inputs to outputs.
- MT ops: HI/LO visible the cycle after the accept edge.

## Structure
- Package muldiv_pkg holds:
  - typedef enum logic [2:0] md_op_t (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6–7 reserved, treated as no-op)
  - typedef enum md_state_t (IDLE, CALC, FIX)
- Counter width: $clog2(WIDTH+1).
- Single module; no sub-module. Negation and the restoring step are inline datapath.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; done exactly 33 cycles after start; busy high for exactly those cycles.
- MULT −3×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Back-to-back MULT issued on the done cycle is accepted.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2.
- Boundary divides, each with normal latency:
  - DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Cancel and start-while-busy, with HI/LO preloaded by MTHI 0x1234 / MTLO 0x5678:
  - Start MULT, cancel at cycle 10 → busy low next cycle, no done, HI/LO still 0x1234/0x5678.
  - A start raised mid-operation is ignored.
- Async reset mid-CALC: HI/LO/busy/done go to 0 without a clock edge. After release, MTHI 0xA5A5A5A5 → HI=0xA5A5A5A5 next cycle, busy stays 0.
